// File: rtl/kv_cache_mem_banked_rmw.sv
// kv_cache_mem_banked_rmw
//   Banked single-port word memory with a valid/ready request port. The low
//   address bits interleave words across NUM_BANK banks. A bit write enable is
//   emulated with a two-cycle read-modify-write (RMW) because the banks have
//   no write mask. A read response follows its accept by exactly one cycle.
//
//   Optional feature macro: KV_MEM_PARITY_EN
//     Each stored word carries one even-parity bit. rsp_perr flags a
//     mismatching parity bit on a read response, or in the RMW write cycle
//     when the word just read back for the merge is corrupt.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid / req_ready  request handshake (accepted when both high)
//   req_wen                1 = write, 0 = read
//   req_addr               word address {row, bank}
//   req_bwe, req_wdata     bit write enable and write data
//   rsp_valid, rsp_rdata   one-cycle read response; rdata holds between responses
//   rmw_busy               RMW write cycle in progress
//   rsp_perr               parity error (KV_MEM_PARITY_EN only)

module kv_cache_mem_banked_rmw #(
   parameter int unsigned DATA_BIT = 128,
   parameter int unsigned DEPTH    = 512,
   parameter int unsigned NUM_BANK = 2,
   parameter int unsigned ADDR_BIT = $clog2(DEPTH * NUM_BANK),
   parameter int unsigned BANK_BIT = $clog2(NUM_BANK)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wen,
   input  logic [ADDR_BIT-1:0] req_addr,
   input  logic [DATA_BIT-1:0] req_bwe,
   input  logic [DATA_BIT-1:0] req_wdata,
   output logic                rsp_valid,
   output logic [DATA_BIT-1:0] rsp_rdata,
   output logic                rmw_busy
`ifdef KV_MEM_PARITY_EN
   ,
   output logic                rsp_perr
`endif
);

   localparam int unsigned ROW_BIT = ADDR_BIT - BANK_BIT;
   localparam int unsigned BSEL_W  = (BANK_BIT > 0) ? BANK_BIT : 1;
`ifdef KV_MEM_PARITY_EN
   localparam int unsigned PAR_BIT = 1;
`else
   localparam int unsigned PAR_BIT = 0;
`endif
   localparam int unsigned MEM_BIT = DATA_BIT + PAR_BIT;

   typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

   state_e              state_q, state_d;
   logic [BSEL_W-1:0]   rmw_bank_q;
   logic [ROW_BIT-1:0]  rmw_row_q;
   logic [DATA_BIT-1:0] rmw_wdata_q, rmw_bwe_q;
   logic                rsp_valid_q;
   logic [BSEL_W-1:0]   rsp_bank_q;
   logic [DATA_BIT-1:0] rsp_hold_q;

   logic [BSEL_W-1:0]   req_bank;
   logic [ROW_BIT-1:0]  req_row;
   logic                bwe_full, bwe_zero, req_partial, req_accept;

   logic                bank_we    [NUM_BANK];
   logic                bank_re    [NUM_BANK];
   logic [ROW_BIT-1:0]  bank_row   [NUM_BANK];
   logic [MEM_BIT-1:0]  bank_wdata [NUM_BANK];
   logic [MEM_BIT-1:0]  bank_dout  [NUM_BANK];

   logic [MEM_BIT-1:0]  rmw_word, rsp_word;
   logic [DATA_BIT-1:0] rmw_merged;

   // Stored word: parity bit (when enabled) above the data.
   function automatic logic [MEM_BIT-1:0] pack(input logic [DATA_BIT-1:0] d);
`ifdef KV_MEM_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   if (NUM_BANK == 1) begin : g_one_bank
      assign req_bank = '0;
      assign req_row  = req_addr;
   end else begin : g_multi_bank
      assign req_bank = req_addr[BANK_BIT-1:0];
      assign req_row  = req_addr[ADDR_BIT-1:BANK_BIT];
   end

   assign bwe_full    = &req_bwe;
   assign bwe_zero    = ~|req_bwe;
   assign req_partial = req_wen & ~bwe_full & ~bwe_zero;
   assign rmw_busy    = (state_q == StRmwWr);

   // During the RMW write cycle the RMW bank port is taken; other banks stay
   // usable for anything that does not itself need an RMW.
   always_comb begin
      req_ready = 1'b1;
      if (state_q == StRmwWr) begin
         req_ready = ~req_partial & (req_bank != rmw_bank_q);
      end
   end

   assign req_accept = req_valid & req_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req_accept && req_partial) state_d = StRmwWr;
         StRmwWr: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign rmw_word   = bank_dout[rmw_bank_q];
   assign rmw_merged = (rmw_wdata_q & rmw_bwe_q) | (rmw_word[DATA_BIT-1:0] & ~rmw_bwe_q);

   // Per-bank port steering; ready guarantees at most one user per bank.
   always_comb begin
      for (int b = 0; b < NUM_BANK; b++) begin
         bank_we[b]    = 1'b0;
         bank_re[b]    = 1'b0;
         bank_row[b]   = '0;
         bank_wdata[b] = '0;
         if (rmw_busy && rmw_bank_q == BSEL_W'(b)) begin
            bank_we[b]    = 1'b1;
            bank_row[b]   = rmw_row_q;
            bank_wdata[b] = pack(rmw_merged);
         end
         if (req_accept && req_bank == BSEL_W'(b)) begin
            if (!req_wen || req_partial) begin
               bank_re[b]  = 1'b1;
               bank_row[b] = req_row;
            end else if (bwe_full) begin
               bank_we[b]    = 1'b1;
               bank_row[b]   = req_row;
               bank_wdata[b] = pack(req_wdata);
            end
         end
      end
   end

   for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
      logic [MEM_BIT-1:0] mem [DEPTH];
      logic [MEM_BIT-1:0] dout_q;

      always_ff @(posedge clk) begin
         if (bank_we[b]) mem[bank_row[b]] <= bank_wdata[b];
         if (bank_re[b]) dout_q <= mem[bank_row[b]];
      end

      assign bank_dout[b] = dout_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rmw_bank_q  <= '0;
         rmw_row_q   <= '0;
         rmw_wdata_q <= '0;
         rmw_bwe_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_bank_q  <= '0;
         rsp_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= req_accept & ~req_wen;
         rsp_hold_q  <= rsp_rdata;
         if (req_accept && !req_wen) rsp_bank_q <= req_bank;
         if (req_accept && req_partial) begin
            rmw_bank_q  <= req_bank;
            rmw_row_q   <= req_row;
            rmw_wdata_q <= req_wdata;
            rmw_bwe_q   <= req_bwe;
         end
      end
   end

   // Bank outputs can change on later RMW reads, so the last response is held.
   assign rsp_word  = bank_dout[rsp_bank_q];
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_valid_q ? rsp_word[DATA_BIT-1:0] : rsp_hold_q;

`ifdef KV_MEM_PARITY_EN
   // Even parity: XOR over data plus stored bit is 0 for a clean word.
   assign rsp_perr = (rsp_valid_q & ^rsp_word) | (rmw_busy & ^rmw_word);
`endif

endmodule
